// File: rtl/sequential_divider_pkg.sv
// ---------------------------------------------------------------------------
// sequential_divider_pkg : shared state encoding and default operand width
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package sequential_divider_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/sequential_divider_subtractor.sv
// ---------------------------------------------------------------------------
// ripple_subtractor : combinational a_i - b_i built from a borrow chain
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ripple_subtractor #(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] diff_o,
  output logic             borrow_o
);

  logic [WIDTH:0] borrow;

  assign borrow[0] = 1'b0;

  // Full-subtractor cell: mirror of the full-adder with borrow in place of carry
  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      assign diff_o[i]   = a_i[i] ^ b_i[i] ^ borrow[i];
      assign borrow[i+1] = (~a_i[i] & b_i[i]) | (~(a_i[i] ^ b_i[i]) & borrow[i]);
    end
  endgenerate

  assign borrow_o = borrow[WIDTH];

endmodule

`default_nettype wire

// File: rtl/sequential_divider.sv
// ---------------------------------------------------------------------------
// sequential_divider : restoring divider, one quotient bit per clock
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sequential_divider
  import sequential_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_Start,
  input  logic [WIDTH-1:0] i_A,
  input  logic [WIDTH-1:0] i_B,
  output logic [WIDTH-1:0] o_Quotient,
  output logic [WIDTH-1:0] o_Remainder,
  output logic             o_Busy,
  output logic             o_Done,
  output logic             o_DivByZero
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  state_t           state_q;
  logic [WIDTH-1:0] quot_q;
  logic [WIDTH-1:0] quot_d;
  logic [WIDTH:0]   rem_q;
  logic [WIDTH:0]   rem_d;
  logic [WIDTH-1:0] div_q;
  logic [CW-1:0]    cnt_q;
  logic             dbz_q;

  logic [WIDTH:0]   shift_rem;
  logic [WIDTH:0]   trial;
  logic             trial_borrow;
  logic             unused_rem_msb;

  // After a restore the partial remainder is below the divisor, so its MSB is always zero
  assign shift_rem      = {rem_q[WIDTH-1:0], quot_q[WIDTH-1]};
  assign unused_rem_msb = rem_q[WIDTH];

  ripple_subtractor #(
    .WIDTH (WIDTH + 1)
  ) u_trial_sub (
    .a_i      (shift_rem),
    .b_i      ({1'b0, div_q}),
    .diff_o   (trial),
    .borrow_o (trial_borrow)
  );

  always_comb begin
    rem_d  = trial_borrow ? shift_rem : trial;
    quot_d = {quot_q[WIDTH-2:0], ~trial_borrow};
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
      quot_q  <= '0;
      rem_q   <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_Start) begin
            if (i_B == '0) begin
              quot_q  <= '1;
              rem_q   <= {1'b0, i_A};
              dbz_q   <= 1'b1;
              state_q <= DONE;
            end else begin
              quot_q  <= i_A;
              div_q   <= i_B;
              rem_q   <= '0;
              cnt_q   <= '0;
              dbz_q   <= 1'b0;
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          quot_q <= quot_d;
          rem_q  <= rem_d;
          cnt_q  <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign o_Quotient  = quot_q;
  assign o_Remainder = rem_q[WIDTH-1:0];
  assign o_Busy      = (state_q != IDLE);
  assign o_Done      = (state_q == DONE);
  assign o_DivByZero = dbz_q;

endmodule

`default_nettype wire

// File: tb/tb_sequential_divider.sv
// ---------------------------------------------------------------------------
// tb_sequential_divider : directed checks for the 4-bit sequential divider
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_sequential_divider;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] a = 4'd0;
  logic [3:0] b = 4'd0;
  logic [3:0] quot;
  logic [3:0] rem;
  logic       busy;
  logic       done;
  logic       dbz;

  int checks = 0;
  int errors = 0;
  int done_seen = 0;

  sequential_divider #(
    .WIDTH (4)
  ) dut (
    .i_clk       (clk),
    .i_reset_n   (rst_n),
    .i_Start     (start),
    .i_A         (a),
    .i_B         (b),
    .o_Quotient  (quot),
    .o_Remainder (rem),
    .o_Busy      (busy),
    .o_Done      (done),
    .o_DivByZero (dbz)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done === 1'b1) done_seen++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Launch one division and wait (bounded) for o_Done; lat counts negedges after the accepting edge
  task automatic run_div(input logic [3:0] ta, input logic [3:0] tb_b,
                         output logic [3:0] q, output logic [3:0] r, output logic dz,
                         output int lat, output logic busy_ok);
    @(negedge clk);
    a = ta; b = tb_b; start = 1'b1;
    lat = 0; busy_ok = 1'b1; q = 4'd0; r = 4'd0; dz = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      start = 1'b0;
      lat++;
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (done === 1'b1) begin
        q = quot; r = rem; dz = dbz;
        break;
      end
    end
  endtask

  logic [3:0] q, r;
  logic       dz, bok;
  int         lat, d0;
  logic [3:0] eq, er;
  logic       edz;
  int         elat;

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_outputs", {27'd0, quot, rem, busy, done, dbz}, 32'd0);
    rst_n = 1'b1;

    // Abort mid-CALC after two iterations
    @(negedge clk);
    a = 4'd13; b = 4'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("midop_busy", {31'd0, busy}, 32'd1);
    d0 = done_seen;
    rst_n = 1'b0;
    #1;
    chk("midop_reset_outputs", {27'd0, quot, rem, busy, done, dbz}, 32'd0);
    repeat (3) @(negedge clk);
    chk("midop_no_done", done_seen - d0, 32'd0);
    rst_n = 1'b1;
    run_div(4'd13, 4'd3, q, r, dz, lat, bok);
    chk("after_reset_13_3", {22'd0, q, r, dz, bok}, {22'd0, 4'd4, 4'd1, 1'b0, 1'b1});

    // Basic divide with latency and single-cycle done
    run_div(4'd13, 4'd3, q, r, dz, lat, bok);
    chk("basic_13_3", {23'd0, q, r, dz}, {23'd0, 4'd4, 4'd1, 1'b0});
    chk("basic_latency", lat, 32'd5);
    @(negedge clk);
    chk("basic_done_pulse", {30'd0, done, busy}, 32'd0);
    chk("basic_hold", {23'd0, quot, rem, dbz}, {23'd0, 4'd4, 4'd1, 1'b0});

    // Divisor larger than dividend, then divide by one
    run_div(4'd3, 4'd7, q, r, dz, lat, bok);
    chk("small_3_7", {23'd0, q, r, dz}, {23'd0, 4'd0, 4'd3, 1'b0});
    run_div(4'd15, 4'd1, q, r, dz, lat, bok);
    chk("div1_15_1", {23'd0, q, r, dz}, {23'd0, 4'd15, 4'd0, 1'b0});

    // Divide by zero and recovery
    run_div(4'd9, 4'd0, q, r, dz, lat, bok);
    chk("dbz_9_0", {23'd0, q, r, dz}, {23'd0, 4'd15, 4'd9, 1'b1});
    chk("dbz_latency", lat, 32'd1);
    @(negedge clk);
    chk("dbz_idle_hold", {22'd0, busy, done, quot, rem, dbz}, {22'd0, 1'b0, 1'b0, 4'd15, 4'd9, 1'b1});
    run_div(4'd8, 4'd2, q, r, dz, lat, bok);
    chk("after_dbz_8_2", {23'd0, q, r, dz}, {23'd0, 4'd4, 4'd0, 1'b0});

    // Start pulse during CALC is ignored
    @(negedge clk);
    d0 = done_seen;
    a = 4'd12; b = 4'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 4'd15; b = 4'd15; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = 4'd0; b = 4'd0;
    for (int i = 0; i < 20; i++) begin
      if (done === 1'b1) break;
      @(negedge clk);
    end
    chk("busy_start_12_5", {22'd0, done, quot, rem, dbz}, {22'd0, 1'b1, 4'd2, 4'd2, 1'b0});
    repeat (8) @(negedge clk);
    chk("busy_start_one_done", done_seen - d0, 32'd1);

    // Exhaustive sweep, back-to-back at earliest legal start
    for (int ai = 0; ai < 16; ai++) begin
      for (int bi = 0; bi < 16; bi++) begin
        run_div(4'(ai), 4'(bi), q, r, dz, lat, bok);
        if (bi == 0) begin
          eq = 4'd15; er = 4'(ai); edz = 1'b1; elat = 1;
        end else begin
          eq = 4'(ai / bi); er = 4'(ai % bi); edz = 1'b0; elat = 5;
        end
        chk($sformatf("sweep_%0d_%0d", ai, bi),
            {14'd0, q, r, dz, bok, lat[7:0]},
            {14'd0, eq, er, edz, 1'b1, elat[7:0]});
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sequential_divider.md
# sequential_divider

- Iterative restoring divider: the inverse arithmetic path to the ripple-carry adder datapath on the FND board.
- Takes a WIDTH-bit dividend and divisor, retires one quotient bit per clock, and returns quotient and remainder with a start/done handshake.
- Feeds the same display formatting path as the adder result; divide-by-zero is flagged rather than producing undefined data.

## Interface
- WIDTH, 4, operand/result width in bits (≥2)
- i_clk  input  1  clock, rising edge
- i_reset_n  input  1  asynchronous, active-low reset
- i_Start  input  1  request; sampled only in IDLE
- i_A  input  WIDTH  dividend
- i_B  input  WIDTH  divisor
- o_Quotient  output  WIDTH  quotient, valid from o_Done until next accepted start
- o_Remainder  output  WIDTH  remainder, same validity
- o_Busy  output  1  high whenever state ≠ IDLE
- o_Done  output  1  one-cycle pulse, results valid
- o_DivByZero  output  1  set with o_Done when i_B was 0; held with results

## Operation
- States: IDLE, CALC, DONE.
- IDLE, i_Start=1, i_B≠0: latch i_A into quotient shift register, i_B into divisor register, clear partial remainder and iteration counter; go to CALC.
- IDLE, i_Start=1, i_B=0: quotient all ones, remainder = i_A, o_DivByZero=1; go straight to DONE.
- CALC, one iteration per edge:
  - shift {remainder, quotient} left by 1;
  - trial = remainder − divisor (WIDTH+1 bits, borrow out);
  - no borrow: remainder = trial, quotient LSB = 1; borrow: restore, LSB = 0.
  - Counter counts 0..WIDTH−1; on the last iteration go to DONE.
- DONE: o_Done=1 for exactly one cycle, then IDLE. Results and o_DivByZero hold until the next accepted start; accepting a start clears o_DivByZero.
- i_Start in CALC or DONE is ignored, not queued. Operand changes after acceptance have no effect.
- All arithmetic is unsigned; the remainder register is WIDTH+1 bits internally and only the low WIDTH bits are output.

## Timing
- Reset (async assert, sync release): state IDLE. o_Quotient=0, o_Remainder=0, o_Busy=0, o_Done=0, o_DivByZero=0; counter 0.
- Start accepted at edge k: o_Busy high after edge k. WIDTH iterations occur at edges k+1..k+WIDTH. o_Done is high in the cycle after edge k+WIDTH, and o_Busy drops after edge k+WIDTH+1.
- Divide-by-zero: o_Done is high in the cycle after edge k; IDLE after edge k+1.
- Earliest back-to-back start: sampled at edge k+WIDTH+2 (normal) or k+2 (div-by-zero).
- Reset asserted mid-CALC: abort immediately, all outputs return to reset values, no o_Done.

## Structure
- Shared package holds the state encoding constants (IDLE, CALC, DONE) and the default WIDTH.
- One sub-module: ripple_subtractor, parameterized WIDTH+1, combinational A−B with borrow out, used for the trial subtraction. It is built as the borrow-chain counterpart of the full-adder cells.

## Test plan
- Reset mid-operation: start 13/3, assert i_reset_n=0 after 2 iterations → all outputs 0 immediately, no o_Done; a following start 13/3 still gives Q=4, R=1.
- Basic divide: start i_A=13, i_B=3 → o_Done pulse 4 edges after acceptance; Q=4, R=1, o_DivByZero=0.
- Divisor larger than dividend: 3/7 → Q=0, R=3. Then 15/1 → Q=15, R=0.
- Divide by zero: 9/0 → o_Done in the cycle after acceptance; Q=15, R=9, o_DivByZero=1. A following 8/2 gives Q=4, R=0, o_DivByZero=0.
- Start while busy: start 12/5, pulse i_Start with 15/15 during CALC → ignored; result Q=2, R=2, exactly one o_Done.
- Exhaustive sweep: all 256 (i_A, i_B) pairs back-to-back at the earliest legal start → matches a reference model every time, and o_Busy never drops between accept and o_Done.
